// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO port bank: register-select codes and bus FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package gpio_bank_pkg;

   localparam logic [2:0] REG_DIR      = 3'd0;
   localparam logic [2:0] REG_OUT      = 3'd1;
   localparam logic [2:0] REG_IN       = 3'd2;
   localparam logic [2:0] REG_OUT_SET  = 3'd3;
   localparam logic [2:0] REG_OUT_CLR  = 3'd4;
   localparam logic [2:0] REG_IRQ_MASK = 3'd5;
   localparam logic [2:0] REG_IRQ_STAT = 3'd6;
   localparam logic [2:0] REG_RSVD     = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for a bus of asynchronous pad inputs.
// Latency: output follows a stable input after 2 clk edges.
// Backpressure: none; free-running every cycle.
module gpio_sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // first stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gpio_port_bank.sv
// Bank of GPIO ports with a simple req/ack register bus; edge interrupts when GPIO_PORT_BANK_IRQ_EN is defined.
// Latency: ack 2 cycles after req is sampled in IDLE; one transaction per 3 cycles at most.
// Backpressure: none; req outside IDLE is ignored, requester must wait for ack.
module gpio_port_bank #(
   parameter int NUM_PORTS = 10,
   parameter int PORT_W    = 8,
   parameter int IDX_W     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req,
   input  logic                        we,
   input  logic [IDX_W+2:0]            addr,
   input  logic [PORT_W-1:0]           wdata,
   output logic [PORT_W-1:0]           rdata,
   output logic                        ack,
   output logic                        err,
   input  logic [NUM_PORTS*PORT_W-1:0] pin_in,
   output logic [NUM_PORTS*PORT_W-1:0] pin_out,
   output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
   output logic                        irq
);

   import gpio_bank_pkg::*;

   state_t              state_q, state_d;
   logic                we_q;
   logic [IDX_W+2:0]    addr_q;
   logic [PORT_W-1:0]   wdata_q;
   logic [PORT_W-1:0]   rdata_q;
   logic                err_q;
   logic [PORT_W-1:0]   rd_val;

   logic [PORT_W-1:0]   dir_q    [NUM_PORTS];
   logic [PORT_W-1:0]   out_q    [NUM_PORTS];
   logic [PORT_W-1:0]   in_sync  [NUM_PORTS];
   logic [PORT_W-1:0]   irq_mask [NUM_PORTS];
   logic [PORT_W-1:0]   irq_stat [NUM_PORTS];

   logic [IDX_W-1:0]    port_q;
   logic [2:0]          sel_q;
   logic                port_ok;
   logic                wr_en;

   assign port_q  = addr_q[IDX_W+2:3];
   assign sel_q   = addr_q[2:0];
   assign port_ok = int'(port_q) < NUM_PORTS;
   // writes to a missing port are dropped so an addressing error never corrupts state
   assign wr_en   = (state_q == ACCESS) && we_q && port_ok;

   // pads are per-port slices; direction and output value come straight from the registers
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      gpio_sync2 #(.W(PORT_W)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (pin_in[p*PORT_W +: PORT_W]),
         .q     (in_sync[p])
      );
      assign pin_out[p*PORT_W +: PORT_W] = out_q[p];
      assign pin_oe[p*PORT_W +: PORT_W]  = dir_q[p];
   end

   // bus FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // bus FSM next state: one cycle each in ACCESS and RESP
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // capture the request only when it is actually accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && req) begin
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // read mux; write-only and reserved selects fall through to zero
   always_comb begin
      rd_val = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (int'(port_q) == p) begin
            case (sel_q)
               REG_DIR:      rd_val = dir_q[p];
               REG_OUT:      rd_val = out_q[p];
               REG_IN:       rd_val = in_sync[p];
               REG_IRQ_MASK: rd_val = irq_mask[p];
               REG_IRQ_STAT: rd_val = irq_stat[p];
               default:      rd_val = '0;
            endcase
         end
      end
   end

   // response is registered at the end of ACCESS and only shown while ack is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_q == ACCESS) begin
         rdata_q <= (we_q || !port_ok) ? '0 : rd_val;
         err_q   <= !port_ok;
      end
   end

   assign ack   = (state_q == RESP);
   assign rdata = ack ? rdata_q : '0;
   assign err   = ack & err_q;

   // direction and output registers, committed at the end of ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            dir_q[p] <= '0;
            out_q[p] <= '0;
         end
      end else if (wr_en) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(port_q) == p) begin
               case (sel_q)
                  REG_DIR:     dir_q[p] <= wdata_q;
                  REG_OUT:     out_q[p] <= wdata_q;
                  REG_OUT_SET: out_q[p] <= out_q[p] | wdata_q;
                  REG_OUT_CLR: out_q[p] <= out_q[p] & ~wdata_q;
                  default:     ;
               endcase
            end
         end
      end
   end

`ifdef GPIO_PORT_BANK_IRQ_EN
   logic [PORT_W-1:0] in_prev [NUM_PORTS];
   logic              irq_any;
   logic              irq_q;

   // rising-edge detect on synchronised inputs; a new edge beats a same-cycle W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            in_prev[p]  <= '0;
            irq_mask[p] <= '0;
            irq_stat[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            in_prev[p] <= in_sync[p];
            if (wr_en && sel_q == REG_IRQ_MASK && int'(port_q) == p)
               irq_mask[p] <= wdata_q;
            irq_stat[p] <= (irq_stat[p] &
                            ~((wr_en && sel_q == REG_IRQ_STAT && int'(port_q) == p) ? wdata_q : '0))
                           | (in_sync[p] & ~in_prev[p]);
         end
      end
   end

   // any unmasked pending bit across all ports
   always_comb begin
      irq_any = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++)
         irq_any = irq_any | (|(irq_stat[p] & irq_mask[p]));
   end

   // interrupt line is registered so it is glitch-free at the pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= irq_any;
   end

   assign irq = irq_q;
`else
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_no_irq
      assign irq_mask[p] = '0;
      assign irq_stat[p] = '0;
   end
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port_bank.sv
// Self-checking bench for gpio_port_bank: directed scenarios plus randomized register traffic.
// Latency: checks ack arrives exactly 2 cycles after each request.
// Backpressure: requester waits for ack before issuing the next access.
module tb_gpio_port_bank;

   localparam int NP = 10;
   localparam int PW = 8;
   localparam int IW = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req = 1'b0;
   logic             we = 1'b0;
   logic [IW+2:0]    addr = '0;
   logic [PW-1:0]    wdata = '0;
   logic [PW-1:0]    rdata;
   logic             ack;
   logic             err;
   logic [NP*PW-1:0] pin_in = '0;
   logic [NP*PW-1:0] pin_out;
   logic [NP*PW-1:0] pin_oe;
   logic             irq;

   int checks = 0;
   int errors = 0;

   // reference model: register contents per port and the pad levels being driven
   logic [PW-1:0] m_dir [NP];
   logic [PW-1:0] m_out [NP];
   logic [PW-1:0] m_pin [NP];

   gpio_port_bank #(.NUM_PORTS(NP), .PORT_W(PW), .IDX_W(IW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .ack     (ack),
      .err     (err),
      .pin_in  (pin_in),
      .pin_out (pin_out),
      .pin_oe  (pin_oe),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [NP*PW-1:0] obs, input logic [NP*PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NP*PW-1:0] pack_model(input logic [PW-1:0] a [NP]);
      logic [NP*PW-1:0] v;
      for (int p = 0; p < NP; p++) v[p*PW +: PW] = a[p];
      return v;
   endfunction

   function automatic logic [PW-1:0] model_read(input int port, input int sel);
      if (port >= NP) return '0;
      case (sel)
         0:       return m_dir[port];
         1:       return m_out[port];
         2:       return m_pin[port];
         default: return '0;
      endcase
   endfunction

   task automatic model_write(input int port, input int sel, input logic [PW-1:0] d);
      if (port < NP) begin
         case (sel)
            0: m_dir[port] = d;
            1: m_out[port] = d;
            3: m_out[port] = m_out[port] | d;
            4: m_out[port] = m_out[port] & ~d;
            default: ;
         endcase
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_dir[p] = '0;
         m_out[p] = '0;
      end
   endtask

   task automatic drive_pins();
      pin_in = pack_model(m_pin);
   endtask

   // one bus access; waits a bounded number of cycles for ack and checks the 2-cycle latency
   task automatic xact(input logic w, input int port, input int sel, input logic [PW-1:0] d,
                       output logic [PW-1:0] rd, output logic e);
      int  cyc;
      bit  got;
      @(negedge clk);
      req   = 1'b1;
      we    = w;
      addr  = {4'(port), 3'(sel)};
      wdata = d;
      @(negedge clk);
      req   = 1'b0;
      we    = 1'b0;
      wdata = '0;
      cyc = 1;
      got = 0;
      rd  = '0;
      e   = 1'b0;
      while (!got && cyc < 8) begin
         if (ack === 1'b1) begin
            got = 1;
            rd  = rdata;
            e   = err;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("ack_latency", NP*PW'(cyc), NP*PW'(2));
   endtask

   task automatic rd_check(input string tag, input int port, input int sel, input logic [PW-1:0] exp);
      logic [PW-1:0] rd;
      logic          e;
      xact(1'b0, port, sel, '0, rd, e);
      check(tag, NP*PW'(rd), NP*PW'(exp));
   endtask

   task automatic wr(input int port, input int sel, input logic [PW-1:0] d);
      logic [PW-1:0] rd;
      logic          e;
      xact(1'b1, port, sel, d, rd, e);
      model_write(port, sel, d);
   endtask

   initial begin
      logic [PW-1:0] rd;
      logic          e;
      int            ack_cnt;
      int            port, sel;
      logic          w;
      logic [PW-1:0] d;

      model_reset();
      for (int p = 0; p < NP; p++) m_pin[p] = '0;
      drive_pins();

      // reset state, observed while reset is held
      #12;
      check("reset_ack", NP*PW'(ack), '0);
      check("reset_err", NP*PW'(err), '0);
      check("reset_rdata", NP*PW'(rdata), '0);
      check("reset_oe", pin_oe, '0);
      check("reset_out", pin_out, '0);
      check("reset_irq", NP*PW'(irq), '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // direction then output on port 0
      wr(0, 0, 8'hF0);
      wr(0, 1, 8'hA5);
      check("p0_oe", NP*PW'(pin_oe[7:0]), NP*PW'(8'hF0));
      check("p0_out", NP*PW'(pin_out[7:0]), NP*PW'(8'hA5));

      // set/clear on port 3; write-only register reads back zero
      wr(3, 1, 8'h0F);
      wr(3, 3, 8'h30);
      wr(3, 4, 8'h03);
      rd_check("p3_out", 3, 1, 8'h3C);
      rd_check("p3_outset_rd", 3, 3, 8'h00);
      rd_check("p3_outclr_rd", 3, 4, 8'h00);

      // input synchroniser lag on port 9: a read starting in the change cycle sees the old value
      @(posedge clk);
      #1;
      m_pin[9] = 8'h81;
      drive_pins();
      rd_check("p9_in_early", 9, 2, 8'h00);
      repeat (2) @(posedge clk);
      rd_check("p9_in_late", 9, 2, 8'h81);

      // out-of-range port index: error, zero data, no state change
      xact(1'b1, 12, 1, 8'hEE, rd, e);
      check("oor_wr_err", NP*PW'(e), NP*PW'(1'b1));
      check("oor_wr_rdata", NP*PW'(rd), '0);
      xact(1'b0, 12, 0, '0, rd, e);
      check("oor_rd_err", NP*PW'(e), NP*PW'(1'b1));
      check("oor_rd_rdata", NP*PW'(rd), '0);
      check("oor_out_intact", pin_out, pack_model(m_out));
      check("oor_oe_intact", pin_oe, pack_model(m_dir));

      // req held high: accepted in IDLE only, so acks land on cycles 2 and 5
      @(negedge clk);
      req  = 1'b1;
      we   = 1'b0;
      addr = {4'd0, 3'd0};
      ack_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (ack === 1'b1) ack_cnt++;
         if (c == 2 || c == 5) check("b2b_ack_slot", NP*PW'(ack), NP*PW'(1'b1));
         if (c == 2) check("b2b_rdata", NP*PW'(rdata), NP*PW'(m_dir[0]));
      end
      req = 1'b0;
      check("b2b_ack_count", NP*PW'(ack_cnt), NP*PW'(2));
      repeat (3) @(negedge clk);

      // randomized traffic against the model, with fresh random pad levels
      for (int p = 0; p < NP; p++) m_pin[p] = PW'($urandom);
      drive_pins();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 60; i++) begin
         port = int'($urandom_range(0, 15));
         sel  = int'($urandom_range(0, 7));
`ifdef GPIO_PORT_BANK_IRQ_EN
         if (sel == 5 || sel == 6) sel = 2;
`endif
         w = 1'($urandom);
         d = PW'($urandom);
         xact(w, port, sel, d, rd, e);
         check("rnd_err", NP*PW'(e), NP*PW'(port >= NP));
         if (w) begin
            check("rnd_wr_rdata", NP*PW'(rd), '0);
            model_write(port, sel, d);
         end else begin
            check("rnd_rd_rdata", NP*PW'(rd), NP*PW'(model_read(port, sel)));
         end
         check("rnd_pin_out", pin_out, pack_model(m_out));
         check("rnd_pin_oe", pin_oe, pack_model(m_dir));
      end

`ifdef GPIO_PORT_BANK_IRQ_EN
      // edge interrupt on port 1 bit 0: set, clear, and set-wins on a coincident clear
      m_pin[1] = 8'h00;
      drive_pins();
      repeat (4) @(negedge clk);
      for (int p = 0; p < NP; p++) wr(p, 6, 8'hFF);
      wr(1, 5, 8'h01);
      m_pin[1] = 8'h01;
      drive_pins();
      repeat (5) @(negedge clk);
      rd_check("irq_stat_set", 1, 6, 8'h01);
      check("irq_high", NP*PW'(irq), NP*PW'(1'b1));
      wr(1, 6, 8'h01);
      @(negedge clk);
      check("irq_cleared", NP*PW'(irq), '0);
      m_pin[1] = 8'h00;
      drive_pins();
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      m_pin[1] = 8'h01;
      drive_pins();
      @(posedge clk);
      wr(1, 6, 8'h01);
      rd_check("irq_set_wins", 1, 6, 8'h01);
`else
      // interrupt registers are absent: read zero, ignore writes, irq stays low
      wr(1, 5, 8'hFF);
      wr(1, 6, 8'hFF);
      rd_check("irq_mask_absent", 1, 5, 8'h00);
      rd_check("irq_stat_absent", 1, 6, 8'h00);
      check("irq_tied_low", NP*PW'(irq), '0);
`endif

      // reset asserted during ACCESS of a write to port 2
      wr(2, 0, 8'h3C);
      @(negedge clk);
      req   = 1'b1;
      we    = 1'b1;
      addr  = {4'd2, 3'd1};
      wdata = 8'hFF;
      @(posedge clk);
      #1;
      req   = 1'b0;
      we    = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_abort_oe", pin_oe, '0);
      check("rst_abort_out", pin_out, '0);
      model_reset();
      ack_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack === 1'b1) ack_cnt++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (ack === 1'b1) ack_cnt++;
      end
      check("rst_abort_no_ack", NP*PW'(ack_cnt), '0);
      rd_check("rst_abort_p2_out", 2, 1, 8'h00);
      rd_check("rst_abort_p2_dir", 2, 0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_port_bank.md
GPIO_PORT_BANK -- requirements
Module: gpio_port_bank

Interface
REQ-001 Parameter NUM_PORTS, default 10, SHALL set the number of ports (1..16).
REQ-002 Parameter PORT_W, default 8, SHALL set the bits per port (1..32).
REQ-003 Parameter IDX_W, default 4, SHALL set the port-index field width (2^IDX_W >= NUM_PORTS).
REQ-004 clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req  in  1  SHALL request a bus transaction, sampled in IDLE.
REQ-007 we  in  1  SHALL select the access type: 1 = write, 0 = read; sampled with req.
REQ-008 addr  in  IDX_W+3  SHALL carry {port index, reg_sel[2:0]}.
REQ-009 wdata  in  PORT_W  SHALL carry the write data.
REQ-010 rdata  out  PORT_W  SHALL carry the read data; valid only while ack=1, otherwise 0.
REQ-011 ack  out  1  SHALL be a one-cycle transaction-complete pulse.
REQ-012 err  out  1  SHALL flag an out-of-range port index; valid with ack.
REQ-013 pin_in  in  NUM_PORTS*PORT_W  SHALL carry the asynchronous pad inputs, port p at bits [p*PORT_W +: PORT_W].
REQ-014 pin_out  out  NUM_PORTS*PORT_W  SHALL carry the pad output values.
REQ-015 pin_oe  out  NUM_PORTS*PORT_W  SHALL carry the per-bit output enables; pads are tristated outside this block.
REQ-016 irq  out  1  SHALL be the OR of all unmasked interrupt status bits.

Function
REQ-017 Register map by reg_sel:
- 0 DIR: R/W; 1 = output.
- 1 OUT: R/W.
- 2 IN: RO, synchronised pins.
- 3 OUT_SET: WO; OUT |= wdata.
- 4 OUT_CLR: WO; OUT &= ~wdata.
- 5 IRQ_MASK: R/W.
- 6 IRQ_STAT: R, write-1-to-clear.
- 7: reserved; reads return 0 and writes are ignored.
REQ-018 Reads of write-only registers SHALL return 0.
REQ-019 pin_oe SHALL equal DIR per bit, and pin_out SHALL equal OUT per bit.
REQ-020 The bus FSM SHALL have states IDLE, ACCESS and RESP, with these transitions:
- IDLE -> ACCESS when req=1 (latch we, addr, wdata).
- ACCESS -> RESP unconditionally; writes commit at the end of ACCESS and rdata is registered.
- RESP -> IDLE unconditionally, with ack=1 in RESP only.
REQ-021 Latency SHALL be exactly 2 cycles from req sampled to ack; maximum throughput SHALL be one transaction per 3 cycles.
REQ-022 req high in the cycle after ack SHALL start a new transaction; req while not in IDLE SHALL be ignored.
REQ-023 A port index >= NUM_PORTS SHALL produce err=1 with ack, rdata=0, and no state change.
REQ-024 Each pin_in bit SHALL pass through a 2-flop synchroniser; IN SHALL lag a pin change by 2 cycles.
REQ-025 A read of IN SHALL return the synchronised value at the ACCESS edge, including bits configured as outputs.

Reset
REQ-026 On rst_n low, immediately and regardless of clk:
- FSM = IDLE, ack = 0, err = 0, rdata = 0.
- DIR = 0 (all inputs), OUT = 0.
- Synchronisers = 0, IRQ_MASK = 0, IRQ_STAT = 0, irq = 0.
REQ-027 A reset during ACCESS or RESP SHALL abort the transaction: no write commits and no ack.
REQ-028 Reset deassertion SHALL be synchronised externally; the FSM leaves IDLE no earlier than the first edge after release.

Configuration
REQ-029 With GPIO_PORT_BANK_IRQ_EN defined, a rising edge on any synchronised input bit SHALL set the corresponding IRQ_STAT bit.
REQ-030 An edge detected in the same cycle as a W1C clear of that bit SHALL leave the bit set (set wins).
REQ-031 irq SHALL be registered, one cycle after the status or mask change.
REQ-032 Without GPIO_PORT_BANK_IRQ_EN, there SHALL be no edge logic; IRQ_MASK/IRQ_STAT SHALL read 0 and ignore writes, and irq SHALL be tied 0.

Structure
REQ-033 Package gpio_bank_pkg SHALL hold the reg_sel constants (REG_DIR..REG_RSVD) and the FSM state encodings (IDLE, ACCESS, RESP).
REQ-034 The synchroniser SHALL be sub-module gpio_sync2 (parameter W), instantiated once per port.

Verification
REQ-035 Write DIR p0 = 8'hF0, then OUT p0 = 8'hA5 -> pin_oe[7:0] = F0, pin_out[7:0] = A5, ack exactly 2 cycles after each req.
REQ-036 OUT p3 = 8'h0F; OUT_SET 8'h30; OUT_CLR 8'h03 -> read OUT p3 = 8'h3C, and reading OUT_SET returns 0.
REQ-037 pin_in p9 = 8'h81 -> read IN p9 gives 8'h81 once 2 cycles have elapsed; reading earlier gives the old value.
REQ-038 Read or write with port index 12 (NUM_PORTS=10) -> ack=1, err=1, rdata=0, no register changes.
REQ-039 IRQ_EN defined, IRQ_MASK p1 = 8'h01, rising edge on p1 bit0 -> IRQ_STAT p1 = 8'h01 and irq=1; W1C 8'h01 -> irq=0; W1C coincident with a new edge -> bit stays 1.
REQ-040 Assert rst_n low during ACCESS of a write OUT p2 = 8'hFF -> ack never asserts, OUT p2 = 0 and pin_oe = 0 immediately.
